// File: rtl/rca_sequencer_pkg.sv
// Shared types and configuration defaults for the RCA instruction sequencer:
// custom-instruction fn3 encodings, sequencer state enum and core sizing defaults.
package rca_sequencer_pkg;

  localparam int CFG_WORDS_DEFAULT = 16;
  localparam int CFG_ID_W_DEFAULT  = 4;

  localparam logic [2:0] USE_FN3    = 3'b000;
  localparam logic [2:0] CONFIG_FN3 = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    CFG_FETCH,
    CFG_WRITE,
    EXEC,
    WB
  } seq_state_e;

endpackage

// File: rtl/rca_sequencer.sv
// Sequencer that loads RCA grid configurations, launches RCA execution and returns results.
// Optional macro RCA_CFG_REUSE_EN skips the reload when the requested configuration is already resident.
module rca_sequencer
  import rca_sequencer_pkg::*;
#(
  parameter  int CFG_WORDS = CFG_WORDS_DEFAULT,
  parameter  int CFG_ID_W  = CFG_ID_W_DEFAULT,
  parameter  int ID_W      = 3,
  localparam int WIDX_W    = $clog2(CFG_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [2:0]                 issue_fn3,
  input  logic [31:0]                issue_rs1,
  input  logic [31:0]                issue_rs2,
  input  logic [ID_W-1:0]            issue_id,
  output logic                       cfg_mem_req,
  output logic [CFG_ID_W+WIDX_W-1:0] cfg_mem_addr,
  input  logic                       cfg_mem_ack,
  input  logic [31:0]                cfg_mem_data,
  output logic                       grid_cfg_we,
  output logic [WIDX_W-1:0]          grid_cfg_addr,
  output logic [31:0]                grid_cfg_data,
  output logic                       rca_start,
  output logic [31:0]                rca_rs1,
  output logic [31:0]                rca_rs2,
  input  logic                       rca_done,
  input  logic [31:0]                rca_result,
  output logic                       wb_valid,
  input  logic                       wb_ack,
  output logic [ID_W-1:0]            wb_id,
  output logic [31:0]                wb_data,
  output logic                       cfg_loaded,
  output logic                       illegal
);

  seq_state_e          r_state;
  logic [WIDX_W-1:0]   r_wordIdx;
  logic [CFG_ID_W-1:0] r_cfgId;
  logic [ID_W-1:0]     r_id;
  logic [31:0]         r_cfgData;
  logic [31:0]         r_rcaRs1;
  logic [31:0]         r_rcaRs2;
  logic [31:0]         r_wbData;
  logic                r_cfgMemReq;
  logic                r_gridWe;
  logic                r_rcaStart;
  logic                r_wbValid;
  logic                r_cfgLoaded;
  logic                r_illegal;

  logic [CFG_ID_W-1:0] w_issueCfgId;
  logic                w_lastWord;
  logic                w_reuse;

  assign w_issueCfgId = issue_rs1[CFG_ID_W-1:0];
  assign w_lastWord   = (r_wordIdx == WIDX_W'(CFG_WORDS - 1));

`ifdef RCA_CFG_REUSE_EN
  // Identity of the resident configuration; only consulted when reuse is enabled.
  logic [CFG_ID_W-1:0] r_loadedId;
  assign w_reuse = r_cfgLoaded && (w_issueCfgId == r_loadedId);
`else
  assign w_reuse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wordIdx   <= '0;
      r_cfgId     <= '0;
      r_id        <= '0;
      r_cfgData   <= '0;
      r_rcaRs1    <= '0;
      r_rcaRs2    <= '0;
      r_wbData    <= '0;
      r_cfgMemReq <= 1'b0;
      r_gridWe    <= 1'b0;
      r_rcaStart  <= 1'b0;
      r_wbValid   <= 1'b0;
      r_cfgLoaded <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef RCA_CFG_REUSE_EN
      r_loadedId  <= '0;
`endif
    end else begin
      r_gridWe   <= 1'b0;
      r_rcaStart <= 1'b0;
      r_illegal  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (issue_valid) begin
            r_id <= issue_id;
            case (issue_fn3)
              CONFIG_FN3: begin
                r_cfgId <= w_issueCfgId;
                if (w_reuse) begin
                  r_wbData  <= 32'(w_issueCfgId);
                  r_wbValid <= 1'b1;
                  r_state   <= WB;
                end else begin
                  r_wordIdx   <= '0;
                  r_cfgLoaded <= 1'b0;
                  r_cfgMemReq <= 1'b1;
                  r_state     <= CFG_FETCH;
                end
              end
              USE_FN3: begin
                if (r_cfgLoaded) begin
                  r_rcaRs1   <= issue_rs1;
                  r_rcaRs2   <= issue_rs2;
                  r_rcaStart <= 1'b1;
                  r_state    <= EXEC;
                end else begin
                  r_wbData  <= 32'hFFFF_FFFF;
                  r_wbValid <= 1'b1;
                  r_state   <= WB;
                end
              end
              default: begin
                r_illegal <= 1'b1;
                r_wbData  <= '0;
                r_wbValid <= 1'b1;
                r_state   <= WB;
              end
            endcase
          end
        end
        CFG_FETCH: begin
          if (cfg_mem_ack) begin
            r_cfgData   <= cfg_mem_data;
            r_cfgMemReq <= 1'b0;
            r_gridWe    <= 1'b1;
            r_state     <= CFG_WRITE;
          end
        end
        CFG_WRITE: begin
          if (w_lastWord) begin
            r_cfgLoaded <= 1'b1;
`ifdef RCA_CFG_REUSE_EN
            r_loadedId  <= r_cfgId;
`endif
            r_wbData    <= 32'(r_cfgId);
            r_wbValid   <= 1'b1;
            r_state     <= WB;
          end else begin
            r_wordIdx   <= r_wordIdx + WIDX_W'(1);
            r_cfgMemReq <= 1'b1;
            r_state     <= CFG_FETCH;
          end
        end
        EXEC: begin
          // The launch cycle itself never counts as completion.
          if (!r_rcaStart && rca_done) begin
            r_wbData  <= rca_result;
            r_wbValid <= 1'b1;
            r_state   <= WB;
          end
        end
        WB: begin
          if (wb_ack) begin
            r_wbValid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign issue_ready   = (r_state == IDLE);
  assign cfg_mem_req   = r_cfgMemReq;
  assign cfg_mem_addr  = {r_cfgId, r_wordIdx};
  assign grid_cfg_we   = r_gridWe;
  assign grid_cfg_addr = r_wordIdx;
  assign grid_cfg_data = r_cfgData;
  assign rca_start     = r_rcaStart;
  assign rca_rs1       = r_rcaRs1;
  assign rca_rs2       = r_rcaRs2;
  assign wb_valid      = r_wbValid;
  assign wb_id         = r_id;
  assign wb_data       = r_wbData;
  assign cfg_loaded    = r_cfgLoaded;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_rca_sequencer.sv
// Directed testbench for rca_sequencer: configuration load, execution, writeback and reset cases.
// Honours RCA_CFG_REUSE_EN when choosing expectations for a repeated CONFIG.
module tb_rca_sequencer;

  localparam int CFG_WORDS = 16;
  localparam int CFG_ID_W  = 4;
  localparam int ID_W      = 3;
  localparam int WIDX_W    = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       issue_valid;
  logic                       issue_ready;
  logic [2:0]                 issue_fn3;
  logic [31:0]                issue_rs1;
  logic [31:0]                issue_rs2;
  logic [ID_W-1:0]            issue_id;
  logic                       cfg_mem_req;
  logic [CFG_ID_W+WIDX_W-1:0] cfg_mem_addr;
  logic                       cfg_mem_ack;
  logic [31:0]                cfg_mem_data;
  logic                       grid_cfg_we;
  logic [WIDX_W-1:0]          grid_cfg_addr;
  logic [31:0]                grid_cfg_data;
  logic                       rca_start;
  logic [31:0]                rca_rs1;
  logic [31:0]                rca_rs2;
  logic                       rca_done;
  logic [31:0]                rca_result;
  logic                       wb_valid;
  logic                       wb_ack;
  logic [ID_W-1:0]            wb_id;
  logic [31:0]                wb_data;
  logic                       cfg_loaded;
  logic                       illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Configuration store returns a word tagged with its own address.
  assign cfg_mem_data = 32'hC0DE_0000 | 32'(cfg_mem_addr);

  rca_sequencer dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn3(issue_fn3),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
    .cfg_mem_req(cfg_mem_req), .cfg_mem_addr(cfg_mem_addr),
    .cfg_mem_ack(cfg_mem_ack), .cfg_mem_data(cfg_mem_data),
    .grid_cfg_we(grid_cfg_we), .grid_cfg_addr(grid_cfg_addr), .grid_cfg_data(grid_cfg_data),
    .rca_start(rca_start), .rca_rs1(rca_rs1), .rca_rs2(rca_rs2),
    .rca_done(rca_done), .rca_result(rca_result),
    .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_id(wb_id), .wb_data(wb_data),
    .cfg_loaded(cfg_loaded), .illegal(illegal)
  );

  // Presents one instruction for a single cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [2:0] fn3, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [ID_W-1:0] id);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_fn3   = fn3;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_id    = id;
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // Holds wb_ack low until wb_valid has been seen holdCycles times, then acks.
  task automatic ackWb(input int holdCycles, output int seen, output logic stable);
    logic [31:0]     d0 = wb_data;
    logic [ID_W-1:0] i0 = wb_id;
    seen   = 0;
    stable = 1'b1;
    while (wb_valid && seen < 20) begin
      seen++;
      if (wb_data !== d0 || wb_id !== i0) stable = 1'b0;
      if (seen >= holdCycles) wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
    end
  endtask

  // Runs a CONFIG and gathers what the grid and store ports saw; stopAtWe > 0 returns early.
  task automatic runConfig(input logic [31:0] rs1, input logic [ID_W-1:0] id, input int stopAtWe,
                           output int latency, output int weCount, output int reqCount,
                           output int badAddr, output int badGrid);
    latency  = -1;
    weCount  = 0;
    reqCount = 0;
    badAddr  = 0;
    badGrid  = 0;
    applyStimulus(3'b001, rs1, 32'd0, id);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (wb_valid) begin
        latency = cyc;
        break;
      end
      if (cfg_mem_req) begin
        reqCount++;
        if (cfg_mem_addr !== {rs1[3:0], 4'(weCount)}) badAddr++;
      end
      if (grid_cfg_we) begin
        if (grid_cfg_addr !== 4'(weCount) ||
            grid_cfg_data !== (32'hC0DE_0000 + rs1[3:0] * 16 + weCount)) badGrid++;
        weCount++;
        if (stopAtWe > 0 && weCount == stopAtWe) break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b0; issue_fn3 = '0; issue_rs1 = '0; issue_rs2 = '0;
    issue_id = '0; cfg_mem_ack = 1'b1; rca_done = 1'b0; rca_result = '0; wb_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", issue_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_loaded: got %b want 0", cfg_loaded); end
    checks++; if (cfg_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfg_mem_req: got %b want 0", cfg_mem_req); end
    checks++; if (grid_cfg_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_grid_we: got %b want 0", grid_cfg_we); end
    checks++; if (rca_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_rca_start: got %b want 0", rca_start); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal); end
    checks++; if (grid_cfg_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_word_idx: got %0d want 0", grid_cfg_addr); end
  endtask

  task automatic test_use_unloaded();
    int   starts = 0;
    int   seen;
    logic stable;
    applyStimulus(3'b000, 32'd5, 32'd7, 3'd1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (rca_start) starts++;
      if (wb_valid) break;
      @(negedge clk);
    end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL unloaded_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL unloaded_wb_data: got %h want ffffffff", wb_data); end
    checks++; if (wb_id !== 3'd1) begin errors++; $display("[TB] FAIL unloaded_wb_id: got %0d want 1", wb_id); end
    checks++; if (starts != 0) begin errors++; $display("[TB] FAIL unloaded_no_start: got %0d starts want 0", starts); end
    ackWb(1, seen, stable);
  endtask

  task automatic test_config();
    int   latency, weCount, reqCount, badAddr, badGrid, seen;
    logic stable;
    runConfig(32'd3, 3'd2, 0, latency, weCount, reqCount, badAddr, badGrid);
    checks++; if (latency != 33) begin errors++; $display("[TB] FAIL config_latency: got %0d want 33", latency); end
    checks++; if (weCount != 16) begin errors++; $display("[TB] FAIL config_we_pulses: got %0d want 16", weCount); end
    checks++; if (reqCount != 16) begin errors++; $display("[TB] FAIL config_req_cycles: got %0d want 16", reqCount); end
    checks++; if (badAddr != 0) begin errors++; $display("[TB] FAIL config_mem_addr: got %0d bad want 0", badAddr); end
    checks++; if (badGrid != 0) begin errors++; $display("[TB] FAIL config_grid_write: got %0d bad want 0", badGrid); end
    checks++; if (wb_data !== 32'd3) begin errors++; $display("[TB] FAIL config_wb_data: got %h want 3", wb_data); end
    checks++; if (wb_id !== 3'd2) begin errors++; $display("[TB] FAIL config_wb_id: got %0d want 2", wb_id); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("[TB] FAIL config_loaded: got %b want 1", cfg_loaded); end
    ackWb(1, seen, stable);
  endtask

  task automatic test_use();
    int          starts = 0;
    int          countdown = 0;
    int          latency = -1;
    int          seen;
    logic        stable;
    logic [31:0] rs1Seen = '0;
    logic [31:0] rs2Seen = '0;
    applyStimulus(3'b000, 32'd5, 32'd7, 3'd5);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (wb_valid) begin
        latency = cyc;
        break;
      end
      rca_done = 1'b0;
      if (rca_start) begin
        starts++;
        rs1Seen    = rca_rs1;
        rs2Seen    = rca_rs2;
        countdown  = 4;
        // A done during the launch cycle must be ignored.
        rca_done   = 1'b1;
        rca_result = 32'hDEAD_BEEF;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          rca_done   = 1'b1;
          rca_result = 32'd12;
        end
      end
      @(negedge clk);
    end
    rca_done = 1'b0;
    checks++; if (starts != 1) begin errors++; $display("[TB] FAIL use_start_pulses: got %0d want 1", starts); end
    checks++; if (rs1Seen !== 32'd5 || rs2Seen !== 32'd7) begin errors++; $display("[TB] FAIL use_operands: got %0d/%0d want 5/7", rs1Seen, rs2Seen); end
    checks++; if (latency != 6) begin errors++; $display("[TB] FAIL use_latency: got %0d want 6", latency); end
    checks++; if (wb_data !== 32'd12) begin errors++; $display("[TB] FAIL use_wb_data: got %h want c", wb_data); end
    checks++; if (wb_id !== 3'd5) begin errors++; $display("[TB] FAIL use_wb_id: got %0d want 5", wb_id); end
    ackWb(3, seen, stable);
    checks++; if (seen != 3) begin errors++; $display("[TB] FAIL use_wb_hold: got %0d cycles want 3", seen); end
    checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL use_wb_stable: got %b want 1", stable); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL use_back_to_idle: got %b want 1", issue_ready); end
  endtask

  task automatic test_illegal();
    int   illegalCount = 0;
    int   readyHigh = 0;
    logic [31:0] dataSeen;
    // Stray wb_ack in IDLE must not disturb anything.
    @(negedge clk);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_ack: got ready=%b valid=%b want 1/0", issue_ready, wb_valid); end
    applyStimulus(3'b111, 32'd1, 32'd2, 3'd6);
    dataSeen = wb_data;
    for (int k = 1; k <= 4; k++) begin
      if (illegal) illegalCount++;
      if (issue_ready) readyHigh++;
      if (k == 4) wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
    end
    checks++; if (illegalCount != 1) begin errors++; $display("[TB] FAIL illegal_pulses: got %0d want 1", illegalCount); end
    checks++; if (dataSeen !== 32'd0) begin errors++; $display("[TB] FAIL illegal_wb_data: got %h want 0", dataSeen); end
    checks++; if (readyHigh != 0) begin errors++; $display("[TB] FAIL illegal_ready_low: got %0d high cycles want 0", readyHigh); end
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL illegal_after_ack: got ready=%b valid=%b want 1/0", issue_ready, wb_valid); end
  endtask

  task automatic test_reset_mid_config();
    int   latency, weCount, reqCount, badAddr, badGrid, seen;
    logic stable;
    runConfig(32'd9, 3'd3, 8, latency, weCount, reqCount, badAddr, badGrid);
    checks++; if (weCount != 8) begin errors++; $display("[TB] FAIL midcfg_reached_word7: got %0d writes want 8", weCount); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("[TB] FAIL midcfg_loaded: got %b want 0", cfg_loaded); end
    checks++; if (issue_ready !== 1'b1 || cfg_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midcfg_idle: got ready=%b req=%b want 1/0", issue_ready, cfg_mem_req); end
    applyStimulus(3'b000, 32'd5, 32'd7, 3'd4);
    checks++; if (wb_valid !== 1'b1 || rca_start !== 1'b0) begin errors++; $display("[TB] FAIL midcfg_use_path: got valid=%b start=%b want 1/0", wb_valid, rca_start); end
    checks++; if (wb_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL midcfg_use_data: got %h want ffffffff", wb_data); end
    ackWb(1, seen, stable);
  endtask

  task automatic test_back_to_back();
    int   latency, weCount, reqCount, badAddr, badGrid, seen;
    int   expLatency, expReq;
    logic stable;
`ifdef RCA_CFG_REUSE_EN
    expLatency = 1;
    expReq     = 0;
`else
    expLatency = 33;
    expReq     = 16;
`endif
    runConfig(32'd3, 3'd1, 0, latency, weCount, reqCount, badAddr, badGrid);
    checks++; if (latency != 33) begin errors++; $display("[TB] FAIL repeat_first_latency: got %0d want 33", latency); end
    ackWb(1, seen, stable);
    runConfig(32'd3, 3'd4, 0, latency, weCount, reqCount, badAddr, badGrid);
    checks++; if (latency != expLatency) begin errors++; $display("[TB] FAIL repeat_latency: got %0d want %0d", latency, expLatency); end
    checks++; if (reqCount != expReq) begin errors++; $display("[TB] FAIL repeat_req_cycles: got %0d want %0d", reqCount, expReq); end
    checks++; if (wb_data !== 32'd3 || wb_id !== 3'd4) begin errors++; $display("[TB] FAIL repeat_wb: got data=%h id=%0d want 3/4", wb_data, wb_id); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("[TB] FAIL repeat_loaded: got %b want 1", cfg_loaded); end
    ackWb(1, seen, stable);
  endtask

  initial begin
    test_reset();
    test_use_unloaded();
    test_config();
    test_use();
    test_illegal();
    test_reset_mid_config();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
